// File: rtl/skid_buffer_pkg.sv
// Shared types and default widths for the skid buffer and its helpers.
package skid_pkg;

  // Default data word width and stall counter width.
  localparam int N_DEF     = 16;
  localparam int CNT_W_DEF = 16;

  // Buffer fill state; encoding doubles as a compact occupancy hint.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  // Number of words held in a given state.
  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      EMPTY:   occ_of = 2'd0;
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer_if.sv
// Handshake bundle of the skid buffer: upstream and downstream valid/ready
// pairs, flush control and debug status.
interface skid_buffer_if
  import skid_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [N-1:0]     data_in;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     data_out;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_count;

  // Environment side: producer, consumer and debug observer.
  modport master (
    output data_in, in_valid, out_ready, flush,
    input  in_ready, data_out, out_valid, occupancy, stall_count
  );

  // Buffer side.
  modport slave (
    input  data_in, in_valid, out_ready, flush,
    output in_ready, data_out, out_valid, occupancy, stall_count
  );

endinterface

// File: rtl/skid_buffer_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Next count value that stops at the top instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 1'b1;
  endfunction

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer. Handshake outputs are decoded from the
// state register only, so out_ready never reaches in_ready combinationally.
module skid_buffer
  import skid_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  skid_buffer_if.slave bus
);

  state_t       state;
  logic [N-1:0] main_p0;
  logic [N-1:0] skid_p0;
  logic         in_fire;
  logic         out_fire;

  // Status decode straight from the state register.
  always_comb begin
    bus.in_ready  = (state != FULL);
    bus.out_valid = (state != EMPTY);
    bus.occupancy = occ_of(state);
    bus.data_out  = main_p0;
    in_fire       = bus.in_valid  & bus.in_ready;
    out_fire      = bus.out_valid & bus.out_ready;
  end

  // Fill state and word storage; flush empties without touching data_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_p0 <= '0;
      skid_p0 <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state   <= BUSY;
            main_p0 <= bus.data_in;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_p0 <= bus.data_in;
          end else if (in_fire) begin
            state   <= FULL;
            skid_p0 <= bus.data_in;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (out_fire) begin
            state   <= BUSY;
            main_p0 <= skid_p0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Downstream stall cycles, counted even in a flush cycle.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.out_valid & ~bus.out_ready),
    .count (bus.stall_count)
  );

endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Two-entry valid/ready pipeline register with registered outputs and full throughput.
- Consumer-facing counterpart to the plain `buffer` stage: accepts words from an upstream producer and presents them to a downstream reader.
- Absorbs back-pressure without a combinational ready path from `out_ready` to `in_ready`.
- Supports pipeline flush and reports occupancy and downstream stall cycles for datapath debug.

Parameters:
- N, 16, data word width in bits.
- CNT_W, 16, width of the stall cycle counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous discard of all held words.
- data_in  input  N  upstream data word.
- in_valid  input  1  upstream word present.
- in_ready  output  1  buffer can accept a word this cycle.
- data_out  output  N  word presented downstream.
- out_valid  output  1  data_out holds a valid word.
- out_ready  input  1  downstream accepts data_out this cycle.
- occupancy  output  2  number of held words, 0..2.
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Storage: main register drives data_out; skid register holds the overflow word.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States:
  - EMPTY (occupancy 0)
  - BUSY (main full, occupancy 1)
  - FULL (main and skid full, occupancy 2)
- Outputs are decoded from the state register only; no combinational input-to-output path:
  - in_ready = (state != FULL)
  - out_valid = (state != EMPTY)
- Transitions from EMPTY:
  - in_fire -> BUSY, main <= data_in.
  - Otherwise stay.
- Transitions from BUSY:
  - in_fire & out_fire -> BUSY, main <= data_in.
  - in_fire & !out_fire -> FULL, skid <= data_in.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise stay.
- Transitions from FULL (in_ready=0, so in_fire is impossible):
  - out_fire -> BUSY, main <= skid.
  - Otherwise stay.
- Latency and throughput:
  - A word accepted at edge k is on data_out with out_valid=1 in the cycle after edge k.
  - Throughput is 1 word/cycle when out_ready is held high.
  - Ordering is strictly FIFO: the skid word never overtakes the main word.
- data_out holds its last value when the buffer goes EMPTY. Downstream must qualify it with out_valid.
- data_out is stable while out_valid=1 and out_ready=0.
- flush has highest priority:
  - Next state is EMPTY regardless of in_fire or out_fire.
  - A word handshaked in the flush cycle is discarded.
  - A word read out in the flush cycle counts as delivered.
  - data_out is not cleared.
- stall_count:
  - Increments on every cycle with out_valid=1 and out_ready=0, including the flush cycle.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Reset values, applied asynchronously:
  - state EMPTY, so in_ready=1, out_valid=0, occupancy=0.
  - data_out=0, skid=0, stall_count=0.
- Reset mid-transfer drops all held words. No handshake completes on the edge where rst is asserted.
- Protocol rule for the producer: it must hold data_in and in_valid until in_fire. The buffer does not check this.

Decomposition:
- Shared package skid_pkg holds:
  - state typedef: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
  - Default width constants N=16 and CNT_W=16.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst, inc; output count). It implements stall_count and is reusable elsewhere in the datapath.

Test Plan:
- Reset: assert rst mid-cycle with two words held -> same time step shows out_valid=0, in_ready=1, occupancy=0, data_out=16'h0000, stall_count=0.
- Streaming: out_ready=1; send 16'h0E20, 16'h0B21, 16'h2388 on consecutive edges -> each appears on data_out one cycle later; in_ready stays 1; occupancy stays at most 1.
- Back-pressure:
  - Setup: out_ready=0; send 16'h0E20 then 16'h0B21.
  - After the second edge: occupancy=2, in_ready=0, data_out=16'h0E20.
  - Holding 16'h2388 valid: it is not accepted.
  - Release out_ready: 16'h0E20, 16'h0B21, 16'h2388 are delivered in order.
- Stall counter:
  - Setup: out_ready=0 for 5 cycles with one word held.
  - Expected: stall_count=5, then holds when out_ready=1.
  - With CNT_W=3: 10 stalled cycles -> stall_count=7.
- Flush: with FULL (16'h0E20, 16'h0B21), assert flush and in_valid with 16'h2388 for one cycle -> next cycle occupancy=0, out_valid=0; no 16'h2388 ever appears valid.
- Simultaneous fire in BUSY: out_ready=1 and in_valid=1 with 16'hAAAA while 16'h5555 is held -> next cycle data_out=16'hAAAA, occupancy=1; 16'h5555 was observed with out_fire exactly once.
